// File: rtl/mac_preact_pkg.sv
// Shared constants and FSM encoding for the activation pipeline
// (the MAC pre-activation stage and the stages downstream of it).
package mac_preact_pkg;

    localparam int ACC_W        = 40;
    localparam int DATA_W       = 16;
    localparam int PROD_W       = 32;
    localparam int FRAC_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

endpackage

// File: rtl/mac_preact_sat_round.sv
// Round-half-up, arithmetic right shift by FRAC, then clip to a signed OUT_W result.
// Purely combinational so any activation stage can register its output as it likes.
module sat_round
    import mac_preact_pkg::*;
#(
    parameter int FRAC  = FRAC_DEFAULT,
    parameter int IN_W  = ACC_W,
    parameter int OUT_W = DATA_W
) (
    input  logic [IN_W-1:0]  i_sum,
    output logic [OUT_W-1:0] o_y,
    output logic             o_sat
);

    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W-1:0] w_rounded;
    logic signed [IN_W-1:0] w_shifted;

    // With no fractional bits there is nothing to round away.
    generate
        if (FRAC > 0) begin : g_rnd
            localparam logic [IN_W-1:0] RND = {{(IN_W-1){1'b0}}, 1'b1} << (FRAC - 1);
            assign w_rounded = $signed(i_sum + RND);
        end else begin : g_nornd
            assign w_rounded = $signed(i_sum);
        end
    endgenerate

    assign w_shifted = w_rounded >>> FRAC;

    always_comb begin
        o_y   = w_shifted[OUT_W-1:0];
        o_sat = 1'b0;
        if (w_shifted > MAX_V) begin
            o_y   = MAX_V[OUT_W-1:0];
            o_sat = 1'b1;
        end else if (w_shifted < MIN_V) begin
            o_y   = MIN_V[OUT_W-1:0];
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/mac_preact.sv
// Streaming Q8.8 dot product plus bias, one pipelined product per beat,
// rounded and saturated to Q8.8 with a one-cycle result latency.
module mac_preact
    import mac_preact_pkg::*;
#(
    parameter int MAX_TERMS = 64,
    parameter int FRAC      = FRAC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_x,
    input  logic [DATA_W-1:0] in_w,
    input  logic              in_last,
    input  logic [DATA_W-1:0] bias,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_y,
    output logic              out_sat,
    output logic              out_len_err
);

    localparam int CNT_W = $clog2(MAX_TERMS + 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [PROD_W-1:0]   r_prod;
    logic                r_prod_v;
    logic [ACC_W-1:0]    r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_trunc;

    logic                w_accept;
    logic signed [PROD_W-1:0] w_prod;
    logic [CNT_W-1:0]    w_cnt_new;
    logic                w_hit_max;
    logic                w_end;
    logic [ACC_W-1:0]    w_bias_acc;
    logic [ACC_W-1:0]    w_prod_ext;
    logic [ACC_W-1:0]    w_sum;
    logic [DATA_W-1:0]   w_y;
    logic                w_sat;

    assign w_accept   = in_valid & in_ready;
    assign w_prod     = $signed(in_x) * $signed(in_w);
    assign w_cnt_new  = (r_state == IDLE) ? CNT_W'(1) : r_cnt + CNT_W'(1);
    assign w_hit_max  = (w_cnt_new == CNT_W'(MAX_TERMS));
    assign w_end      = in_last | w_hit_max;
    assign w_bias_acc = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias} << FRAC;
    assign w_prod_ext = {{(ACC_W-PROD_W){r_prod[PROD_W-1]}}, r_prod};
    // The last product is still in flight when DRAIN is entered.
    assign w_sum      = r_acc + w_prod_ext;

    sat_round #(
        .FRAC  (FRAC),
        .IN_W  (ACC_W),
        .OUT_W (DATA_W)
    ) u_sat_round (
        .i_sum (w_sum),
        .o_y   (w_y),
        .o_sat (w_sat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (w_accept) begin
                    w_state_next = w_end ? DRAIN : ACCUM;
                end
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (w_accept && w_end) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                w_state_next = OUT;
            end
            OUT: begin
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prod      <= '0;
            r_prod_v    <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_trunc     <= 1'b0;
            out_valid   <= 1'b0;
            out_y       <= '0;
            out_sat     <= 1'b0;
            out_len_err <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_acc    <= w_bias_acc;
                        r_prod   <= w_prod;
                        r_prod_v <= 1'b1;
                        r_cnt    <= w_cnt_new;
                        r_trunc  <= ~in_last & w_hit_max;
                    end
                end
                ACCUM: begin
                    if (r_prod_v) begin
                        r_acc <= w_sum;
                    end
                    if (w_accept) begin
                        r_prod   <= w_prod;
                        r_prod_v <= 1'b1;
                        r_cnt    <= w_cnt_new;
                        if (!in_last && w_hit_max) begin
                            r_trunc <= 1'b1;
                        end
                    end else begin
                        r_prod_v <= 1'b0;
                    end
                end
                DRAIN: begin
                    out_y       <= w_y;
                    out_sat     <= w_sat;
                    out_len_err <= r_trunc;
                    out_valid   <= 1'b1;
                    r_prod_v    <= 1'b0;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_preact.sv
// Scoreboard bench for mac_preact: a default-size instance and a MAX_TERMS=4
// instance share one input bus; sel chooses which one sees in_valid.
module tb_mac_preact;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_x = '0;
    logic [15:0] in_w = '0;
    logic [15:0] bias = '0;

    logic        rdy_a, ov_a, sat_a, len_a;
    logic [15:0] y_a;
    logic        rdy_b, ov_b, sat_b, len_b;
    logic [15:0] y_b;

    logic        w_rdy, w_ov, w_sat, w_len;
    logic [15:0] w_y;

    typedef struct {
        logic [15:0] y;
        logic        sat;
        logic        len;
    } exp_t;

    exp_t   sb_q[$];
    int     n_cmp = 0;
    int     n_err = 0;
    longint m_sum = 0;
    int     m_cnt = 0;

    always #5 clk = ~clk;

    mac_preact #(.MAX_TERMS(64), .FRAC(8)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(rdy_a),
        .in_x(in_x), .in_w(in_w), .in_last(in_last), .bias(bias),
        .out_valid(ov_a), .out_ready(out_ready), .out_y(y_a),
        .out_sat(sat_a), .out_len_err(len_a)
    );

    mac_preact #(.MAX_TERMS(4), .FRAC(8)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(rdy_b),
        .in_x(in_x), .in_w(in_w), .in_last(in_last), .bias(bias),
        .out_valid(ov_b), .out_ready(out_ready), .out_y(y_b),
        .out_sat(sat_b), .out_len_err(len_b)
    );

    assign w_rdy = sel ? rdy_b : rdy_a;
    assign w_ov  = sel ? ov_b  : ov_a;
    assign w_y   = sel ? y_b   : y_a;
    assign w_sat = sel ? sat_b : sat_a;
    assign w_len = sel ? len_b : len_a;

    task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model_out(input longint s, input logic len);
        exp_t   e;
        longint r;
        r = (s + 128) >>> 8;
        e.len = len;
        if (r > 32767) begin
            e.y = 16'h7FFF; e.sat = 1'b1;
        end else if (r < -32768) begin
            e.y = 16'h8000; e.sat = 1'b1;
        end else begin
            e.y = r[15:0];  e.sat = 1'b0;
        end
        return e;
    endfunction

    // Drive one beat, wait for acceptance, and update the reference model.
    task automatic beat(input logic [15:0] x, input logic [15:0] w, input logic last);
        int waited = 0;
        int max_t;
        in_x = x; in_w = w; in_last = last; in_valid = 1'b1;
        @(negedge clk);
        while (!w_rdy && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!w_rdy) begin
            chk("beat_accept", 40'd0, 40'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        max_t = sel ? 4 : 64;
        if (m_cnt == 0) m_sum = longint'($signed(bias)) * 256;
        m_sum += longint'($signed(x)) * longint'($signed(w));
        m_cnt++;
        if (last || m_cnt == max_t) begin
            sb_q.push_back(model_out(m_sum, ~last));
            m_cnt = 0;
        end
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb_q.size() != 0 || w_ov) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (sb_q.size() != 0 || w_ov) chk("drain_timeout", 40'd0, 40'd1);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && w_ov && out_ready) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_out", 40'd1, 40'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                $display("OUT dut=%s y=%04h sat=%0b len_err=%0b (exp %04h/%0b/%0b)",
                         sel ? "max4" : "max64", w_y, w_sat, w_len, e.y, e.sat, e.len);
                chk("out_y", {24'd0, w_y}, {24'd0, e.y});
                chk("out_sat", {39'd0, w_sat}, {39'd0, e.sat});
                chk("out_len_err", {39'd0, w_len}, {39'd0, e.len});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {39'd0, w_ov}, 40'd0);
        chk("rst_in_ready", {39'd0, w_rdy}, 40'd1);
        chk("rst_out_y", {24'd0, w_y}, 40'd0);
        chk("rst_out_sat", {39'd0, w_sat}, 40'd0);
        chk("rst_len_err", {39'd0, w_len}, 40'd0);
        @(posedge clk); #1;

        // Single beat: 1.0 + 2.0*1.5 = 4.0, result one cycle after acceptance
        bias = 16'h0100;
        beat(16'h0200, 16'h0180, 1'b1);
        @(negedge clk);
        chk("lat_drain_ov", {39'd0, w_ov}, 40'd0);
        @(negedge clk);
        chk("lat_ov", {39'd0, w_ov}, 40'd1);
        chk("single_y", {24'd0, w_y}, 40'h0400);
        wait_idle();

        // Positive and negative saturation
        bias = 16'h0000;
        for (int i = 0; i < 4; i++) beat(16'h7FFF, 16'h7FFF, i == 3);
        wait_idle();
        beat(16'h8000, 16'h7FFF, 1'b1);
        wait_idle();

        // Rounding at the half-LSB boundary
        beat(16'h0001, 16'h0080, 1'b1);
        beat(16'h0001, 16'h007F, 1'b1);
        beat(16'hFFFF, 16'h0080, 1'b1);
        wait_idle();

        // Back-pressure: result must hold and input must stay blocked
        out_ready = 1'b0;
        bias = 16'h0010;
        beat(16'h0100, 16'h0300, 1'b1);
        @(negedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("stall_ov", {39'd0, w_ov}, 40'd1);
            chk("stall_y", {24'd0, w_y}, 40'h0310);
            chk("stall_rdy", {39'd0, w_rdy}, 40'd0);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post_hs_rdy", {39'd0, w_rdy}, 40'd1);
        chk("post_hs_ov", {39'd0, w_ov}, 40'd0);
        @(posedge clk); #1;

        // Gaps in in_valid mid-vector, negative bias
        bias = 16'hFF00;
        beat(16'h0300, 16'h0200, 1'b0);
        idle(3);
        beat(16'hFE80, 16'h0100, 1'b0);
        idle(1);
        beat(16'h0040, 16'hFFC0, 1'b1);
        wait_idle();

        // Random vectors with random gaps
        for (int v = 0; v < 6; v++) begin
            int len;
            len  = $urandom_range(1, 10);
            bias = 16'($urandom);
            for (int b = 0; b < len; b++) begin
                beat(16'($urandom), 16'($urandom), b == len - 1);
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
            end
        end
        wait_idle();

        // Truncation at MAX_TERMS=4: beats 5-7 form the next vector
        sel  = 1'b1;
        bias = 16'h0020;
        for (int i = 1; i <= 6; i++) beat(16'(i * 16'h0100), 16'h0080, 1'b0);
        beat(16'h0100, 16'h0100, 1'b1);
        wait_idle();
        sel = 1'b0;

        // Reset mid-vector discards the partial sum
        bias = 16'h0000;
        for (int i = 0; i < 3; i++) beat(16'h0400, 16'h0400, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        m_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_ov", {39'd0, w_ov}, 40'd0);
        end
        @(posedge clk); #1;
        bias = 16'h0080;
        for (int i = 0; i < 8; i++) beat(16'(16'h0100 + i * 16'h0010), 16'hFF00, i == 7);
        wait_idle();

        chk("sb_empty", 40'(sb_q.size()), 40'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mac_preact.md
MAC_PREACT -- requirements
Module: mac_preact

Interface
REQ-001 The block SHALL have parameter MAX_TERMS, default 64, giving the maximum beats per vector (2..256).
REQ-002 The block SHALL have parameter FRAC, default 8, giving the fractional bits of the Q8.8 signed data (0x0100 = 1.0).
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit, meaning the beat on in_x/in_w/in_last is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts a beat this cycle.
REQ-007 The block SHALL have ports in_x and in_w, each input, 16 bits, the signed Q8.8 activation and weight.
REQ-008 The block SHALL have port in_last, input, 1 bit, marking the final beat of a vector.
REQ-009 The block SHALL have port bias, input, 16 bits, a signed Q8.8 value sampled only on the first beat of a vector.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning the result is valid.
REQ-011 The block SHALL have port out_ready, input, 1 bit, meaning downstream (the tanh stage) accepts the result.
REQ-012 The block SHALL have port out_y, output, 16 bits, the signed Q8.8 pre-activation result.
REQ-013 The block SHALL have port out_sat, output, 1 bit, set when out_y was clipped.
REQ-014 The block SHALL have port out_len_err, output, 1 bit, set when a vector was truncated at MAX_TERMS.

Function
REQ-015 The FSM SHALL have states IDLE, ACCUM, DRAIN and OUT; in_ready SHALL be 1 exactly in IDLE and ACCUM.
REQ-016 A beat SHALL be accepted on a clock edge where in_valid and in_ready are both 1.
REQ-017 On an accepted beat, prod_reg SHALL load the full 32-bit signed product in_x*in_w, and prod_v SHALL be set.
REQ-018 When no beat is accepted, prod_v SHALL clear after prod_reg has been added to the accumulator.
REQ-019 On the first accepted beat in IDLE, acc (40-bit signed) SHALL load sign-extended bias<<FRAC and the beat counter SHALL load 1.
REQ-020 In ACCUM, acc SHALL add sign-extended prod_reg on each edge where prod_v=1, whether or not a new beat is accepted on that edge.
REQ-021 An accepted beat with in_last=1 SHALL move the FSM to DRAIN; otherwise the FSM SHALL go from IDLE to ACCUM.
REQ-022 The beat that makes the counter equal MAX_TERMS without in_last SHALL be treated as last, and out_len_err SHALL be latched to 1 for that vector.
REQ-023 In DRAIN, with sum = acc + prod_reg, the block SHALL compute r = (sum + 2^(FRAC-1)) >>> FRAC, i.e. round half-up with an arithmetic shift.
REQ-024 In DRAIN, the block SHALL saturate r to [-32768, 32767], register it into out_y and out_sat, set out_valid, and go to OUT.
REQ-025 Latency SHALL be exactly 1 cycle: out_valid rises on the edge after the edge that accepted the last beat.
REQ-026 In OUT, out_y, out_sat and out_len_err SHALL hold stable while out_ready=0.
REQ-027 On an edge in OUT where out_ready=1, out_valid SHALL clear and the FSM SHALL go to IDLE; in_ready SHALL be 1 on the following cycle.
REQ-028 A single-beat vector (in_last on the first beat) SHALL be valid and yield round(bias + x*w).
REQ-029 Gaps in in_valid during ACCUM SHALL be allowed without affecting the result.
REQ-030 A 40-bit acc SHALL never overflow for MAX_TERMS ≤ 256; the block SHALL have no wrap-around.

Reset
REQ-031 When rst=1 at an edge, the block SHALL set state=IDLE and clear out_valid, out_sat, out_len_err, prod_v, the counter, acc and out_y to 0.
REQ-032 A reset asserted mid-vector or in OUT SHALL discard the partial result, and no out_valid SHALL follow.

Structure
REQ-033 FSM state encodings, the default FRAC and the ACC_W=40 constant SHALL live in the shared package used by the activation blocks.
REQ-034 The round-and-saturate logic SHALL be one sub-module, sat_round (40-bit in, 16-bit out plus sat flag), reusable by other activation stages.

Verification
REQ-035 Bias 0x0100 with one beat x=0x0200, w=0x0180, last=1 -> out_y=0x0400, out_sat=0, out_valid one cycle after acceptance.
REQ-036 Four beats x=w=0x7FFF with bias 0 -> out_y=0x7FFF, out_sat=1; one beat x=0x8000, w=0x7FFF -> out_y=0x8000, out_sat=1.
REQ-037 Rounding with bias 0: (0x0001, 0x0080) -> 0x0001; (0x0001, 0x007F) -> 0x0000; (0xFFFF, 0x0080) -> 0x0000.
REQ-038 Result ready with out_ready=0 for 5 cycles -> out_y stable and in_ready=0 throughout; on release, one handshake, then in_ready=1.
REQ-039 With MAX_TERMS=4, six beats with no in_last -> result covers beats 1-4 with out_len_err=1, and beats 5-6 start a new vector.
REQ-040 rst pulsed after 3 of 8 beats -> no out_valid, and the next full vector gives the correct sum.
